// File: rtl/turbo_block_interleaver.sv
// Frame interleaver/deinterleaver: buffers N soft values, replays them QPP-permuted.
// Optional framing check on in_last is enabled by defining TURBO_INTLV_LAST_CHECK_EN.
module turbo_block_interleaver #(
    parameter int N      = 10,
    parameter int W      = 8,
    parameter int F1     = 1,
    parameter int F2     = 0,
    parameter int OFFSET = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mode,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         frame_err
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW:0]   N_EXT    = (CW+1)'(N);
    localparam logic [CW-1:0] PI0      = CW'(OFFSET % N);
    localparam logic [CW-1:0] G0       = CW'((F1 + F2) % N);
    localparam logic [CW-1:0] D        = CW'((2 * F2) % N);
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    typedef enum logic {FILL, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] pi_q, pi_d;
    logic [CW-1:0] g_q, g_d;
    logic          mode_q, mode_d;
    logic [W-1:0]  mem_q [N];

    logic          wr_en;
    logic [CW-1:0] wr_addr;
    logic [CW-1:0] rd_addr;
    logic          advance;
    logic          restart;

    // Both operands are already reduced mod N, so one conditional subtract suffices.
    function automatic logic [CW-1:0] mod_add(input logic [CW-1:0] a, input logic [CW-1:0] b);
        logic [CW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= N_EXT) s = s - N_EXT;
        return s[CW-1:0];
    endfunction

`ifdef TURBO_INTLV_LAST_CHECK_EN
    logic frame_err_q, frame_err_d;
`else
    logic unused_in_last;
    assign unused_in_last = in_last;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        wr_en   = 1'b0;
        wr_addr = cnt_q;
        advance = 1'b0;
        restart = 1'b0;
`ifdef TURBO_INTLV_LAST_CHECK_EN
        frame_err_d = 1'b0;
`endif
        case (state_q)
            FILL: begin
                if (in_valid) begin
                    // Beat 0 uses the live mode input since mode_q is only being loaded now.
                    wr_en   = 1'b1;
                    wr_addr = (((cnt_q == '0) ? mode : mode_q)) ? pi_q : cnt_q;
                    if (cnt_q == '0) mode_d = mode;
                    if (cnt_q == LAST_IDX) begin
                        state_d = DRAIN;
                        cnt_d   = '0;
                        restart = 1'b1;
`ifdef TURBO_INTLV_LAST_CHECK_EN
                        frame_err_d = !in_last;
`endif
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        advance = 1'b1;
`ifdef TURBO_INTLV_LAST_CHECK_EN
                        if (in_last) begin
                            frame_err_d = 1'b1;
                            wr_en       = 1'b0;
                            cnt_d       = '0;
                            advance     = 1'b0;
                            restart     = 1'b1;
                        end
`endif
                    end
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (cnt_q == LAST_IDX) begin
                        state_d = FILL;
                        cnt_d   = '0;
                        restart = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        advance = 1'b1;
                    end
                end
            end
            default: state_d = FILL;
        endcase

        pi_d = pi_q;
        g_d  = g_q;
        if (restart) begin
            pi_d = PI0;
            g_d  = G0;
        end else if (advance) begin
            pi_d = mod_add(pi_q, g_q);
            g_d  = mod_add(g_q, D);
        end

        rd_addr   = mode_q ? cnt_q : pi_q;
        in_ready  = (state_q == FILL);
        out_valid = (state_q == DRAIN);
        out_data  = out_valid ? mem_q[rd_addr] : '0;
        out_last  = out_valid && (cnt_q == LAST_IDX);
`ifdef TURBO_INTLV_LAST_CHECK_EN
        frame_err = frame_err_q;
`else
        frame_err = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            cnt_q   <= '0;
            pi_q    <= PI0;
            g_q     <= G0;
            mode_q  <= 1'b0;
`ifdef TURBO_INTLV_LAST_CHECK_EN
            frame_err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pi_q    <= pi_d;
            g_q     <= g_d;
            mode_q  <= mode_d;
`ifdef TURBO_INTLV_LAST_CHECK_EN
            frame_err_q <= frame_err_d;
`endif
        end
    end

    // Frame buffer carries no reset; it is always fully rewritten before being read.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= in_data;
    end

endmodule

// File: tb/tb_turbo_block_interleaver.sv
// Bench for turbo_block_interleaver: default cyclic-shift instance and an N=40 QPP instance,
// checked against an arithmetic permutation model with random gaps and stalls.
module tb_turbo_block_interleaver;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         mode = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_last = 1'b0;
    logic         out_ready = 1'b0;
    logic         sel = 1'b0;

    logic         a_in_ready, a_out_valid, a_out_last, a_frame_err;
    logic [W-1:0] a_out_data;
    logic         b_in_ready, b_out_valid, b_out_last, b_frame_err;
    logic [W-1:0] b_out_data;

    logic         o_in_ready, o_out_valid, o_out_last, o_frame_err;
    logic [W-1:0] o_out_data;

    always #5 clk = ~clk;

    turbo_block_interleaver dut_a (
        .clk(clk), .rst(rst), .mode(mode),
        .in_valid(in_valid && !sel), .in_ready(a_in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(a_out_valid), .out_ready(out_ready && !sel), .out_data(a_out_data),
        .out_last(a_out_last), .frame_err(a_frame_err)
    );

    turbo_block_interleaver #(.N(40), .W(W), .F1(3), .F2(10), .OFFSET(0)) dut_b (
        .clk(clk), .rst(rst), .mode(mode),
        .in_valid(in_valid && sel), .in_ready(b_in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(b_out_valid), .out_ready(out_ready && sel), .out_data(b_out_data),
        .out_last(b_out_last), .frame_err(b_frame_err)
    );

    assign o_in_ready  = sel ? b_in_ready  : a_in_ready;
    assign o_out_valid = sel ? b_out_valid : a_out_valid;
    assign o_out_data  = sel ? b_out_data  : a_out_data;
    assign o_out_last  = sel ? b_out_last  : a_out_last;
    assign o_frame_err = sel ? b_frame_err : a_frame_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cn, cf1, cf2, coff;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    logic [W-1:0] data_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pi_f(input int i);
        return (coff + cf1 * i + cf2 * i * i) % cn;
    endfunction

    task automatic select(input bit s);
        sel = s;
        if (s) begin cn = 40; cf1 = 3; cf2 = 10; coff = 0; end
        else   begin cn = 10; cf1 = 1; cf2 = 0;  coff = 1; end
    endtask

    task automatic build_exp(input bit m, input logic [W-1:0] d[$]);
        logic [W-1:0] tmp[$];
        exp_q.delete();
        if (!m) begin
            for (int i = 0; i < cn; i++) exp_q.push_back(d[pi_f(i)]);
        end else begin
            for (int i = 0; i < cn; i++) tmp.push_back('0);
            for (int i = 0; i < cn; i++) tmp[pi_f(i)] = d[i];
            for (int i = 0; i < cn; i++) exp_q.push_back(tmp[i]);
        end
    endtask

    // Drives beats 0..last_at (or all cn beats if last_at >= cn); mode toggles after beat 0.
    task automatic send_frame(input bit m, input logic [W-1:0] d[$], input bit gaps, input int last_at);
        int cnt;
        int t;
        cnt = (last_at < cn) ? last_at + 1 : cn;
        for (int k = 0; k < cnt; k++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                mode = $urandom_range(0, 1);
                @(negedge clk);
            end
            t = 0;
            while (!o_in_ready && t < 50) begin @(negedge clk); t++; end
            check("fill_in_ready", o_in_ready, 1);
            check("fill_out_valid", o_out_valid, 0);
            mode     = (k == 0) ? m : ~m;
            in_valid = 1'b1;
            in_data  = d[k];
            in_last  = (k == last_at);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic recv_frame(input bit stalls, input int rst_at);
        logic [W-1:0] pd;
        logic         pl;
        got_q.delete();
        for (int j = 0; j < cn; j++) begin
            check("drain_out_valid", o_out_valid, 1);
            check("drain_in_ready", o_in_ready, 0);
            if (stalls) repeat ($urandom_range(0, 2)) begin
                out_ready = 1'b0;
                pd = o_out_data;
                pl = o_out_last;
                @(negedge clk);
                check("stall_data_stable", o_out_data, pd);
                check("stall_last_stable", o_out_last, pl);
                check("stall_in_ready", o_in_ready, 0);
            end
            if (j == rst_at) begin
                rst = 1'b1;
                #1;
                check("rst_out_valid", o_out_valid, 0);
                check("rst_out_data", o_out_data, 0);
                check("rst_out_last", o_out_last, 0);
                @(negedge clk);
                rst = 1'b0;
                out_ready = 1'b0;
                @(negedge clk);
                check("post_rst_in_ready", o_in_ready, 1);
                return;
            end
            out_ready = 1'b1;
            check($sformatf("out_data[%0d]", j), o_out_data, exp_q[j]);
            check($sformatf("out_last[%0d]", j), o_out_last, (j == cn - 1));
            got_q.push_back(o_out_data);
            @(negedge clk);
        end
        out_ready = 1'b0;
        check("end_out_valid", o_out_valid, 0);
        check("end_in_ready", o_in_ready, 1);
    endtask

    task automatic ramp();
        data_q.delete();
        for (int i = 0; i < cn; i++) data_q.push_back(W'(i));
    endtask

    task automatic rand_data();
        data_q.delete();
        for (int i = 0; i < cn; i++) data_q.push_back(W'($urandom));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit m;
        select(0);
        repeat (3) @(negedge clk);
        check("rst_a_out_valid", a_out_valid, 0);
        check("rst_b_out_valid", b_out_valid, 0);
        check("rst_a_out_data", a_out_data, 0);
        check("rst_a_out_last", a_out_last, 0);
        check("rst_a_frame_err", a_frame_err, 0);
        check("rst_b_frame_err", b_frame_err, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rel_a_in_ready", a_in_ready, 1);
        check("rel_b_in_ready", b_in_ready, 1);

        // Default forward and reverse on a ramp
        ramp();
        send_frame(0, data_q, 0, cn - 1); build_exp(0, data_q); recv_frame(0, -1);
        send_frame(1, data_q, 0, cn - 1); build_exp(1, data_q); recv_frame(0, -1);

        // QPP N=40 forward, then round trip through reverse
        select(1);
        ramp();
        send_frame(0, data_q, 0, cn - 1); build_exp(0, data_q); recv_frame(0, -1);
        data_q = got_q;
        send_frame(1, data_q, 0, cn - 1); build_exp(1, data_q); recv_frame(0, -1);
        for (int i = 0; i < cn; i++) check($sformatf("roundtrip[%0d]", i), got_q[i], i);

        // Randomized traffic with gaps and stalls
        for (int r = 0; r < 8; r++) begin
            select($urandom_range(0, 1));
            m = $urandom_range(0, 1);
            rand_data();
            send_frame(m, data_q, 1, cn - 1); build_exp(m, data_q); recv_frame(1, -1);
        end

        // Reset at output beat 4, then a clean frame
        select(0);
        rand_data();
        send_frame(0, data_q, 0, cn - 1); build_exp(0, data_q); recv_frame(0, 4);
        rand_data();
        send_frame(1, data_q, 1, cn - 1); build_exp(1, data_q); recv_frame(1, -1);

`ifdef TURBO_INTLV_LAST_CHECK_EN
        rand_data();
        send_frame(0, data_q, 0, 5);
        check("early_last_err", o_frame_err, 1);
        @(negedge clk);
        check("early_last_err_clr", o_frame_err, 0);
        check("early_last_no_out", o_out_valid, 0);
        check("early_last_in_ready", o_in_ready, 1);
        rand_data();
        send_frame(0, data_q, 1, cn - 1); build_exp(0, data_q);
        check("clean_no_err", o_frame_err, 0);
        recv_frame(1, -1);
        rand_data();
        send_frame(1, data_q, 0, cn);
        check("missing_last_err", o_frame_err, 1);
        build_exp(1, data_q); recv_frame(0, -1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
